axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- AXI-style memory responder: the slave end of the load/store bus that the execute unit's LSU drives as master.
- Independent read and write channels, byte-strobed writes into an internal word array, and configurable response latency so the bench can stress LSU stall paths.
- Sits below the execute unit in the simulation top and in unit benches; replaces a DPI memory model for the data side.

Parameters:
- BASE_ADDR, 64'h8000_0000, first byte address mapped to word 0
- DEPTH_LOG2, 12, log2 of the number of 64-bit words (4096 words = 32 KiB)
- RD_LAT, 2, cycles from AR handshake to R_VALID assertion (>=1)
- WR_LAT, 1, cycles from capture of both AW and W to B_VALID assertion (>=1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- axi_AW_ADDR  in  64  write byte address
- axi_AW_VALID  in  1  write address valid
- axi_AW_READY  out  1  write address accepted
- axi_W_DATA  in  64  write data
- axi_W_STRB  in  8  byte enables; bit i covers W_DATA[8i+7:8i]
- axi_W_VALID  in  1  write data valid
- axi_W_READY  out  1  write data accepted
- axi_B_VALID  out  1  write response valid
- axi_B_READY  in  1  master accepts write response
- axi_AR_ADDR  in  64  read byte address
- axi_AR_VALID  in  1  read address valid
- axi_AR_READY  out  1  read address accepted
- axi_R_DATA  out  64  read data, full 64-bit word
- axi_R_VALID  out  1  read data valid
- axi_R_READY  in  1  master accepts read data

Behaviour:
Addressing:
- word index = ((ADDR - BASE_ADDR) >> 3) modulo 2^DEPTH_LOG2; ADDR[2:0] ignored.
- Out-of-range addresses wrap silently; there is no error response.

Reset values:
- AW_READY=1, W_READY=1, AR_READY=1, B_VALID=0, R_VALID=0, R_DATA=0.
- Both FSMs reset to IDLE and both latency counters to 0.
- Memory contents are not reset.
- Reset asserted mid-transaction drops the transaction: any pending write that has not committed is lost, and no B or R beat is produced afterwards.

Write FSM (WS_IDLE, WS_DELAY, WS_RESP):
- WS_IDLE: AW_READY = ~aw_captured; W_READY = ~w_captured.
- AW and W are accepted in either order or in the same cycle; address and data/strobe are registered on their own handshake.
- When both are captured (same cycle as the second handshake), go to WS_DELAY with cnt=WR_LAT-1, and drop both readys.
- WS_DELAY: decrement cnt. At cnt==0, commit the strobed write to memory in that cycle and go to WS_RESP.
- WS_RESP: B_VALID=1, held until B_READY. On the handshake, clear the captured flags and return to WS_IDLE; readys reassert the next cycle.
- Throughput: at most one outstanding write; minimum is 2+WR_LAT cycles per write when B_READY is already high.

Read FSM (RS_IDLE, RS_DELAY, RS_DATA):
- RS_IDLE: AR_READY=1. On the AR handshake, latch the index, go to RS_DELAY with cnt=RD_LAT-1, and drop AR_READY.
- RS_DELAY: at cnt==0, load R_DATA from memory and go to RS_DATA. Otherwise decrement.
- RS_DATA: R_VALID=1. R_DATA is stable until R_READY. On the handshake, R_VALID=0 and the FSM returns to RS_IDLE.
- Latency: R_VALID rises exactly RD_LAT cycles after the AR handshake edge.

Simultaneous events:
- Read and write FSMs are fully independent and may overlap.
- Same-cycle write commit and R_DATA load to the same word: the read returns the pre-write data (read-before-write).
- A later read always sees a committed earlier write.
- A strobe of 8'h00 completes normally (B issued) and leaves memory unchanged.
- VALID deasserted by the master before a handshake is tolerated: nothing is captured.

Decomposition:
- Package axi_sram_pkg holds:
  - wr_state_e / rd_state_e enums
  - BYTE_LANES=8, WORD_BYTES_LOG2=3
  - an addr_to_index function (parameterised by BASE_ADDR and DEPTH_LOG2 via a localparam in the module)
- One sub-module sram_1r1w_be: 1 synchronous read port and 1 write port with byte enables, DEPTH_LOG2 x 64; read-before-write on address collision.
- The top module contains the two FSMs and the handshake logic.

Test Plan:
- Write then read back: AW+W same cycle, addr 0x8000_0010, data 0x1122334455667788, strb 0xFF; then AR same addr -> B_VALID after 2 cycles; R_DATA=0x1122334455667788 exactly 2 cycles after the AR handshake.
- Byte strobe merge: preload 0xFFFF_FFFF_FFFF_FFFF at 0x8000_0020, write 0x0000_0000_0000_00AB strb 0x01 -> readback 0xFFFF_FFFF_FFFF_FFAB; strb 0x00 write -> B issued, data unchanged.
- AW/W ordering: W valid 3 cycles before AW; then AW before W -> each captured once, readys drop individually, single B per write, correct data committed.
- Backpressure: hold R_READY=0 and B_READY=0 for 5 cycles -> R_VALID/B_VALID and R_DATA held stable; AR_READY/AW_READY stay 0 until the handshake.
- Wrap and collision: read at BASE+(4096<<3) returns word 0; same-cycle commit and read-load to one word returns the old value; next read returns the new value.
- Reset mid-read: assert rst_n=0 while in RS_DELAY -> R_VALID=0, AR_READY=1 after release, no stray R beat.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// ---------------------------------------------------------------------------
// axi_sram_pkg
// Shared types and helpers for the AXI-style SRAM responder.
//   wr_state_e / rd_state_e : write and read channel FSM states
//   BYTE_LANES              : byte enables per 64-bit word
//   WORD_BYTES_LOG2         : log2 of bytes per word (byte address -> word)
//   addr_to_index()         : byte address -> wrapped word index
// ---------------------------------------------------------------------------
package axi_sram_pkg;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_DELAY,
    WS_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_DELAY,
    RS_DATA
  } rd_state_e;

  localparam int BYTE_LANES      = 8;
  localparam int WORD_BYTES_LOG2 = 3;

  // Offset from the base, drop the byte-within-word bits, then wrap into the
  // array. Out-of-range addresses alias silently; the caller truncates the
  // result to its own index width.
  function automatic logic [63:0] addr_to_index(input logic [63:0] addr,
                                                input logic [63:0] base_addr,
                                                input int          depth_log2);
    logic [63:0] offset;
    logic [63:0] mask;
    offset = addr - base_addr;
    mask   = (64'd1 << depth_log2) - 64'd1;
    return (offset >> WORD_BYTES_LOG2) & mask;
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// ---------------------------------------------------------------------------
// axi_sram_slave_if
// Load/store bus between the LSU (master) and the SRAM responder (slave).
//   AW_ADDR/AW_VALID/AW_READY : write address channel
//   W_DATA/W_STRB/W_VALID/W_READY : write data channel, W_STRB[i] covers
//                                   W_DATA[8i+7:8i]
//   B_VALID/B_READY           : write response channel
//   AR_ADDR/AR_VALID/AR_READY : read address channel
//   R_DATA/R_VALID/R_READY    : read data channel
// ---------------------------------------------------------------------------
interface axi_sram_slave_if;

  logic [63:0] AW_ADDR;
  logic        AW_VALID;
  logic        AW_READY;
  logic [63:0] W_DATA;
  logic [7:0]  W_STRB;
  logic        W_VALID;
  logic        W_READY;
  logic        B_VALID;
  logic        B_READY;
  logic [63:0] AR_ADDR;
  logic        AR_VALID;
  logic        AR_READY;
  logic [63:0] R_DATA;
  logic        R_VALID;
  logic        R_READY;

  modport slave (
    input  AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
           AR_ADDR, AR_VALID, R_READY,
    output AW_READY, W_READY, B_VALID, AR_READY, R_DATA, R_VALID
  );

  modport master (
    output AW_ADDR, AW_VALID, W_DATA, W_STRB, W_VALID, B_READY,
           AR_ADDR, AR_VALID, R_READY,
    input  AW_READY, W_READY, B_VALID, AR_READY, R_DATA, R_VALID
  );

endinterface

// File: rtl/sram_1r1w_be.sv
// ---------------------------------------------------------------------------
// sram_1r1w_be
// 2^DEPTH_LOG2 x 64-bit word array, one synchronous read port and one
// byte-enabled write port. On a same-cycle read and write of one word the
// read returns the old contents.
//   clk, rst_n : clock, async active-low reset (read register only)
//   rd_en      : load rd_data from mem[rd_idx] on the next rising edge
//   rd_idx     : read word index
//   rd_data    : registered read data, holds its value while rd_en is low
//   wr_en      : commit a write on the next rising edge
//   wr_idx     : write word index
//   wr_data    : write data
//   wr_be      : byte enables, bit i covers wr_data[8i+7:8i]
// ---------------------------------------------------------------------------
module sram_1r1w_be
  import axi_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [63:0]           rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [63:0]           wr_data,
  input  logic [BYTE_LANES-1:0] wr_be
);

  logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (wr_be[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Non-blocking update of the array above means a colliding read sees the
  // pre-write word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI-style memory responder for the LSU data side. Independent read and
// write channels with fixed, configurable response latencies and byte-strobed
// writes into an internal word array.
//   clk   : clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset
//   axi   : slave side of the load/store bus (see axi_sram_slave_if)
// Parameters:
//   BASE_ADDR  : byte address mapped to word 0
//   DEPTH_LOG2 : log2 of the number of 64-bit words
//   RD_LAT     : cycles from AR handshake to R_VALID (>=1)
//   WR_LAT     : cycles from AW+W capture to B_VALID (>=1)
// ---------------------------------------------------------------------------
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          RD_LAT     = 2,
  parameter int          WR_LAT     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_sram_slave_if.slave  axi
);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  localparam logic [7:0] RD_CNT_INIT = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_CNT_INIT = 8'(WR_LAT - 1);

  // ---------------- write channel ----------------
  wr_state_e               wr_state;
  wr_state_e               wr_state_next;
  logic                    aw_captured;
  logic                    w_captured;
  idx_t                    aw_idx;
  logic [63:0]             w_data_q;
  logic [BYTE_LANES-1:0]   w_strb_q;
  logic [7:0]              wr_cnt;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_hs;
  logic                    wr_both;
  logic                    wr_commit;

  // ---------------- read channel -----------------
  rd_state_e               rd_state;
  rd_state_e               rd_state_next;
  idx_t                    ar_idx;
  logic [7:0]              rd_cnt;
  logic                    ar_hs;
  logic                    r_hs;
  logic                    rd_load;

  assign aw_hs = axi.AW_VALID & axi.AW_READY;
  assign w_hs  = axi.W_VALID  & axi.W_READY;
  assign b_hs  = axi.B_VALID  & axi.B_READY;
  assign ar_hs = axi.AR_VALID & axi.AR_READY;
  assign r_hs  = axi.R_VALID  & axi.R_READY;

  // True in the cycle the second half of a write is (or already was) taken,
  // so AW and W may arrive in either order or together.
  assign wr_both = (aw_captured | aw_hs) & (w_captured | w_hs);

  // ================= write FSM =================

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WS_IDLE;
    end else begin
      wr_state <= wr_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WS_IDLE:  if (wr_both)         wr_state_next = WS_DELAY;
      WS_DELAY: if (wr_cnt == 8'd0)  wr_state_next = WS_RESP;
      WS_RESP:  if (b_hs)            wr_state_next = WS_IDLE;
      default:                       wr_state_next = WS_IDLE;
    endcase
  end

  // Each ready drops on its own once that half is held, and both stay low
  // from capture of the pair until the B handshake.
  always_comb begin
    axi.AW_READY = 1'b0;
    axi.W_READY  = 1'b0;
    axi.B_VALID  = 1'b0;
    wr_commit    = 1'b0;
    case (wr_state)
      WS_IDLE: begin
        axi.AW_READY = ~aw_captured;
        axi.W_READY  = ~w_captured;
      end
      WS_DELAY: wr_commit   = (wr_cnt == 8'd0);
      WS_RESP:  axi.B_VALID = 1'b1;
      default: ;
    endcase
  end

  // Capture registers, captured flags and the write latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      aw_idx      <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      wr_cnt      <= '0;
    end else begin
      if (aw_hs) begin
        aw_captured <= 1'b1;
        aw_idx      <= idx_t'(addr_to_index(axi.AW_ADDR, BASE_ADDR, DEPTH_LOG2));
      end
      if (w_hs) begin
        w_captured <= 1'b1;
        w_data_q   <= axi.W_DATA;
        w_strb_q   <= axi.W_STRB;
      end
      if (b_hs) begin
        aw_captured <= 1'b0;
        w_captured  <= 1'b0;
      end
      if (wr_state == WS_IDLE && wr_both) begin
        wr_cnt <= WR_CNT_INIT;
      end else if (wr_state == WS_DELAY && wr_cnt != 8'd0) begin
        wr_cnt <= wr_cnt - 8'd1;
      end
    end
  end

  // ================= read FSM ==================

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RS_IDLE;
    end else begin
      rd_state <= rd_state_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RS_IDLE:  if (ar_hs)           rd_state_next = RS_DELAY;
      RS_DELAY: if (rd_cnt == 8'd0)  rd_state_next = RS_DATA;
      RS_DATA:  if (r_hs)            rd_state_next = RS_IDLE;
      default:                       rd_state_next = RS_IDLE;
    endcase
  end

  // The SRAM read register doubles as R_DATA, so loading it only on the
  // last delay cycle keeps R_DATA stable while the master stalls.
  always_comb begin
    axi.AR_READY = 1'b0;
    axi.R_VALID  = 1'b0;
    rd_load      = 1'b0;
    case (rd_state)
      RS_IDLE:  axi.AR_READY = 1'b1;
      RS_DELAY: rd_load      = (rd_cnt == 8'd0);
      RS_DATA:  axi.R_VALID  = 1'b1;
      default: ;
    endcase
  end

  // Latched read index and the read latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_idx <= '0;
      rd_cnt <= '0;
    end else begin
      if (ar_hs) begin
        ar_idx <= idx_t'(addr_to_index(axi.AR_ADDR, BASE_ADDR, DEPTH_LOG2));
        rd_cnt <= RD_CNT_INIT;
      end else if (rd_state == RS_DELAY && rd_cnt != 8'd0) begin
        rd_cnt <= rd_cnt - 8'd1;
      end
    end
  end

  // ================= storage ===================

  sram_1r1w_be #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_en   (rd_load),
    .rd_idx  (ar_idx),
    .rd_data (axi.R_DATA),
    .wr_en   (wr_commit),
    .wr_idx  (aw_idx),
    .wr_data (w_data_q),
    .wr_be   (w_strb_q)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Self-checking bench for axi_sram_slave. Expected data comes from a word
// array indexed by plain address arithmetic; latencies come from the
// parameters.
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam logic [63:0] BASE       = 64'h8000_0000;
  localparam int          DEPTH_LOG2 = 12;
  localparam int          WORDS      = 4096;
  localparam int          RD_LAT     = 2;
  localparam int          WR_LAT     = 1;
  localparam int          TIMEOUT    = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] model_mem [int];

  axi_sram_slave_if bus ();

  axi_sram_slave #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axi   (bus)
  );

  always #5 clk = ~clk;

  // Word the memory should hold for a byte address: offset, divide by the
  // word size, wrap by the array size.
  function automatic int word_of(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE;
    return int'((off / 64'd8) % 64'(WORDS));
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w,
                                        input logic [63:0] new_w,
                                        input logic [7:0]  strb);
    logic [63:0] r;
    r = old_w;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Master-side inputs to their idle values.
  task automatic applyStimulus();
    bus.AW_ADDR  = '0;
    bus.AW_VALID = 1'b0;
    bus.W_DATA   = '0;
    bus.W_STRB   = '0;
    bus.W_VALID  = 1'b0;
    bus.B_READY  = 1'b0;
    bus.AR_ADDR  = '0;
    bus.AR_VALID = 1'b0;
    bus.R_READY  = 1'b0;
  endtask

  // One write. AW and W each raise VALID after their own delay and keep it up
  // until both halves were taken; B is stalled b_hold cycles.
  task automatic write_txn(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input int aw_delay,
                           input int w_delay, input int b_hold);
    int aw_hs = 0;
    int w_hs  = 0;
    int cyc   = 0;
    int lat   = 0;
    int idx;
    bus.AW_ADDR = addr;
    bus.W_DATA  = data;
    bus.W_STRB  = strb;
    while ((aw_hs == 0 || w_hs == 0) && cyc < TIMEOUT) begin
      bus.AW_VALID = (cyc >= aw_delay);
      bus.W_VALID  = (cyc >= w_delay);
      #1;
      checkOutput("aw_ready_idle", 64'(bus.AW_READY), 64'(aw_hs == 0));
      checkOutput("w_ready_idle",  64'(bus.W_READY),  64'(w_hs == 0));
      if (bus.AW_VALID && bus.AW_READY) aw_hs++;
      if (bus.W_VALID && bus.W_READY) w_hs++;
      @(negedge clk);
      cyc++;
    end
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    checkOutput("aw_once", 64'(aw_hs), 64'(1));
    checkOutput("w_once",  64'(w_hs),  64'(1));
    idx = word_of(addr);
    model_mem[idx] = merge(model_mem.exists(idx) ? model_mem[idx] : 64'h0,
                           data, strb);
    checkOutput("aw_ready_busy", 64'(bus.AW_READY), 64'(0));
    checkOutput("w_ready_busy",  64'(bus.W_READY),  64'(0));
    while (!bus.B_VALID && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b_latency", 64'(lat), 64'(WR_LAT));
    repeat (b_hold) begin
      checkOutput("b_hold_valid",    64'(bus.B_VALID),  64'(1));
      checkOutput("b_hold_aw_ready", 64'(bus.AW_READY), 64'(0));
      @(negedge clk);
    end
    bus.B_READY = 1'b1;
    @(negedge clk);
    bus.B_READY = 1'b0;
    #1;
    checkOutput("b_done",         64'(bus.B_VALID),  64'(0));
    checkOutput("aw_ready_back",  64'(bus.AW_READY), 64'(1));
    checkOutput("w_ready_back",   64'(bus.W_READY),  64'(1));
  endtask

  // One read, R stalled r_hold cycles, data compared against exp.
  task automatic read_txn(input logic [63:0] addr, input int r_hold,
                          input logic [63:0] exp);
    int lat = 0;
    bus.AR_ADDR  = addr;
    bus.AR_VALID = 1'b1;
    #1;
    checkOutput("ar_ready_idle", 64'(bus.AR_READY), 64'(1));
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    #1;
    checkOutput("ar_ready_busy", 64'(bus.AR_READY), 64'(0));
    while (!bus.R_VALID && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("r_latency", 64'(lat), 64'(RD_LAT));
    checkOutput("r_data", bus.R_DATA, exp);
    repeat (r_hold) begin
      checkOutput("r_hold_valid",    64'(bus.R_VALID),  64'(1));
      checkOutput("r_hold_data",     bus.R_DATA,        exp);
      checkOutput("r_hold_ar_ready", 64'(bus.AR_READY), 64'(0));
      @(negedge clk);
    end
    bus.R_READY = 1'b1;
    @(negedge clk);
    bus.R_READY = 1'b0;
    #1;
    checkOutput("r_done",        64'(bus.R_VALID),  64'(0));
    checkOutput("ar_ready_back", 64'(bus.AR_READY), 64'(1));
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    logic [63:0] coll_addr;
    logic [63:0] old_w;
    logic [63:0] new_w;
    logic        stray;
    int          d;
    int          words [8];

    applyStimulus();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_aw_ready", 64'(bus.AW_READY), 64'(1));
    checkOutput("rst_w_ready",  64'(bus.W_READY),  64'(1));
    checkOutput("rst_ar_ready", 64'(bus.AR_READY), 64'(1));
    checkOutput("rst_b_valid",  64'(bus.B_VALID),  64'(0));
    checkOutput("rst_r_valid",  64'(bus.R_VALID),  64'(0));
    checkOutput("rst_r_data",   bus.R_DATA,        64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] write then read back");
    write_txn(BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 0);
    read_txn(BASE + 64'h10, 0, 64'h1122_3344_5566_7788);

    $display("[TB] byte strobe merge");
    write_txn(BASE + 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0);
    write_txn(BASE + 64'h20, 64'h0000_0000_0000_00AB, 8'h01, 0, 0, 0);
    read_txn(BASE + 64'h20, 0, 64'hFFFF_FFFF_FFFF_FFAB);
    write_txn(BASE + 64'h20, 64'h0123_4567_89AB_CDEF, 8'h00, 0, 0, 0);
    read_txn(BASE + 64'h20, 0, 64'hFFFF_FFFF_FFFF_FFAB);

    $display("[TB] AW/W ordering");
    write_txn(BASE + 64'h30, 64'hA5A5_0000_1111_2222, 8'hFF, 3, 0, 0);
    write_txn(BASE + 64'h38, 64'h5A5A_3333_4444_5555, 8'hFF, 0, 3, 0);
    read_txn(BASE + 64'h30, 0, 64'hA5A5_0000_1111_2222);
    read_txn(BASE + 64'h38, 0, 64'h5A5A_3333_4444_5555);

    $display("[TB] backpressure");
    write_txn(BASE + 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 0, 0, 5);
    read_txn(BASE + 64'h40, 5, 64'hDEAD_BEEF_CAFE_F00D);

    $display("[TB] wrap");
    write_txn(BASE, 64'h0F0F_0F0F_1234_5678, 8'hFF, 0, 0, 0);
    read_txn(BASE + (64'(WORDS) << 3), 0, 64'h0F0F_0F0F_1234_5678);
    write_txn(BASE + (64'(WORDS) << 3) + 64'h0D, 64'h7777_6666_5555_4444, 8'hF0, 1, 0, 0);
    read_txn(BASE + 64'h8, 0, model_mem[word_of(BASE + 64'h8)]);

    $display("[TB] read/commit collision");
    coll_addr = BASE + 64'h48;
    old_w     = 64'h0101_0202_0303_0404;
    new_w     = 64'hF1F2_F3F4_F5F6_F7F8;
    write_txn(coll_addr, old_w, 8'hFF, 0, 0, 0);
    d = RD_LAT - WR_LAT;
    bus.AR_ADDR = coll_addr;
    bus.AW_ADDR = coll_addr;
    bus.W_DATA  = new_w;
    bus.W_STRB  = 8'hFF;
    for (int c = 0; c <= d; c++) begin
      bus.AR_VALID = (c == 0);
      bus.AW_VALID = (c == d);
      bus.W_VALID  = (c == d);
      @(negedge clk);
    end
    bus.AR_VALID = 1'b0;
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    repeat (WR_LAT) @(negedge clk);
    checkOutput("coll_r_valid", 64'(bus.R_VALID), 64'(1));
    checkOutput("coll_b_valid", 64'(bus.B_VALID), 64'(1));
    checkOutput("coll_old_data", bus.R_DATA, old_w);
    bus.R_READY = 1'b1;
    bus.B_READY = 1'b1;
    @(negedge clk);
    bus.R_READY = 1'b0;
    bus.B_READY = 1'b0;
    model_mem[word_of(coll_addr)] = new_w;
    read_txn(coll_addr, 0, new_w);

    $display("[TB] reset during read delay");
    bus.AR_ADDR  = BASE + 64'h10;
    bus.AR_VALID = 1'b1;
    @(negedge clk);
    bus.AR_VALID = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_r_valid",  64'(bus.R_VALID),  64'(0));
    checkOutput("mid_rst_ar_ready", 64'(bus.AR_READY), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      stray = stray | bus.R_VALID | bus.B_VALID;
    end
    checkOutput("no_stray_beat",     64'(stray),        64'(0));
    checkOutput("post_rst_ar_ready", 64'(bus.AR_READY), 64'(1));
    read_txn(BASE + 64'h10, 0, model_mem[word_of(BASE + 64'h10)]);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 8; i++) begin
      words[i] = int'($urandom_range(WORDS - 1, 0));
      write_txn(BASE + 64'(words[i]) * 64'd8, {$urandom, $urandom}, 8'hFF, 0, 0, 0);
    end
    for (int n = 0; n < 40; n++) begin
      int          w;
      logic [63:0] a;
      w = words[$urandom_range(7, 0)];
      a = BASE + 64'(w) * 64'd8
          + 64'($urandom_range(3, 0)) * (64'(WORDS) << 3)
          + 64'($urandom_range(7, 0));
      if ($urandom_range(1, 0) == 1) begin
        write_txn(a, {$urandom, $urandom}, 8'($urandom),
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(3, 0)));
      end else begin
        read_txn(a, int'($urandom_range(3, 0)), model_mem[w]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
